vsim_msg_fifo: RTL and testbench
================================

Name: vsim_msg_fifo

Overview:
- Store-and-forward message buffer between the simulator word source and the user design's `read` PipeIn port.
- Accepts 32-bit words tagged with an end-of-message flag. Presents words downstream only once a complete message is held, so the user logic never stalls mid-message waiting on the host.
- Falls back to cut-through when a message exceeds buffer depth, which avoids deadlock.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, word entries; power of two, minimum 2.
- CW, log2(DEPTH)+1, width of `level` and `msg_count`.

Ports:
- CLK  in  1  sole clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- enq__ENA  in  1  upstream offers a word this cycle.
- enq$v  in  WIDTH  upstream word data.
- enq$last  in  1  word is the final word of its message.
- enq__RDY  out  1  buffer can accept a word.
- deq__ENA  in  1  downstream takes the head word this cycle.
- deq$v  out  WIDTH  head word data.
- deq$last  out  1  head word's last flag.
- deq__RDY  out  1  head word is valid and releasable.
- level  out  CW  words currently stored.
- msg_count  out  CW  complete messages stored (last flags in buffer).
- proto_err  out  1  sticky; set on ENA asserted while the matching RDY is low.

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous, active-low, nRST.
- Reset values: pointers, level, msg_count, cut_through flag and proto_err all 0. Outputs: enq__RDY=1, deq__RDY=0, deq$v=0, deq$last=0.
- Storage: register array plus wrapping read/write pointers of CW bits each.
  - full when the pointers differ only in the MSB; empty when the pointers are equal.
- Enqueue: fires when enq__ENA & enq__RDY. Writes {enq$last, enq$v} at wptr, then wptr+1.
  - enq__RDY = !full (combinational from registered state).
  - A word enqueued at edge N is visible at the head from cycle N+1.
- Dequeue: fires when deq__ENA & deq__RDY; rptr+1.
  - deq$v and deq$last are a combinational read of entry rptr; they must read 0 when empty.
  - deq__RDY = !empty & (msg_count != 0 | cut_through).
- msg_count: +1 on an enqueue with last=1, -1 on a dequeue with last=1. Both in the same cycle leaves it unchanged.
- level: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Simultaneous enqueue and dequeue when neither full nor empty: both take effect.
  - Full blocks enqueue regardless of deq__ENA; there is no same-cycle pass-through.
  - Empty blocks dequeue even if an enqueue occurs that cycle.
- Cut-through state (2 states: STORE, CUT):
  - STORE -> CUT when full & msg_count==0 (the oversize message would deadlock).
  - CUT -> STORE on the edge where a word with last=1 is dequeued.
  - In CUT, deq__RDY follows !empty only.
  - Messages queued behind the oversize one are still governed by msg_count after returning to STORE.
- Protocol violations: enq__ENA while !enq__RDY, or deq__ENA while !deq__RDY.
  - The offending request is ignored with no state change except proto_err, which sets at the next edge.
  - proto_err is cleared only by reset.
- Pointer wrap-around is natural modulo 2*DEPTH; there are no special cases.
- Reset mid-message: all stored words and partial messages are discarded asynchronously. The downstream sees deq__RDY drop immediately.

Test Plan:
1. After reset, enqueue 3 words 0xA0,0xA1,0xA2 (last on 0xA2) at cycles 1-3. Required:
   - deq__RDY stays 0 through cycle 3 and rises at cycle 4.
   - Dequeue yields 0xA0,0xA1,0xA2 with deq$last only on 0xA2; msg_count 1->0; level 3->0.
2. Two 2-word messages back-to-back, dequeue held continuously asserted. Required:
   - The second message streams immediately after the first with no bubble.
   - msg_count is unchanged in the cycle where one last is enqueued and another dequeued.
3. DEPTH=16 with a 20-word message. Required:
   - Full at word 16, enq__RDY=0, and CUT is entered.
   - deq__RDY rises the next cycle; all 20 words arrive in order.
   - The state returns to STORE after the last-word dequeue; level ends at 0.
4. Fill, drain and refill 5 times with single-word messages 0x100+i. Required:
   - Data order is correct across pointer wrap.
   - level never exceeds 16; the full and empty flags are exact at the boundaries.
5. Assert enq__ENA while full, then deq__ENA while deq__RDY=0. Required:
   - No change to level or data.
   - proto_err=1 from the next cycle and it stays 1 until nRST.
6. Deassert nRST asynchronously, mid-clock, with 5 words stored (partial message). Required:
   - deq__RDY=0, level=0, msg_count=0 immediately, without waiting for a clock edge.
   - The first post-reset message is delivered cleanly.

Source files
------------

// File: rtl/vsim_msg_fifo.sv
// Store-and-forward message FIFO feeding the user design's read PipeIn port.
// Ports: CLK/nRST; enq__ENA/enq_v/enq_last/enq__RDY word input;
//        deq__ENA/deq_v/deq_last/deq__RDY head output;
//        level, msg_count, proto_err status.
module vsim_msg_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enq__ENA,
    input  logic [WIDTH-1:0] enq_v,
    input  logic             enq_last,
    output logic             enq__RDY,
    input  logic             deq__ENA,
    output logic [WIDTH-1:0] deq_v,
    output logic             deq_last,
    output logic             deq__RDY,
    output logic [CW-1:0]    level,
    output logic [CW-1:0]    msg_count,
    output logic             proto_err
);

    localparam int AW = CW - 1;

    localparam logic [0:0] STORE = 1'b0;
    localparam logic [0:0] CUT   = 1'b1;

    logic [WIDTH:0]  mem [DEPTH];
    logic [CW-1:0]   wPtr;
    logic [CW-1:0]   rPtr;
    logic [0:0]      cutState;
    logic [WIDTH:0]  headWord;
    logic            full;
    logic            empty;
    logic            enqFire;
    logic            deqFire;
    logic            enqLast;
    logic            deqLast;
    logic            protoHit;

    assign full  = (wPtr[AW] != rPtr[AW]) &&
                   (wPtr[AW-1:0] == rPtr[AW-1:0]);
    assign empty = (wPtr == rPtr);

    assign headWord = mem[rPtr[AW-1:0]];

    assign enq__RDY = !full;
    // In CUT the oversize message streams out before its last word arrives.
    assign deq__RDY = !empty &&
                      ((msg_count != '0) || (cutState == CUT));

    assign deq_v    = empty ? '0 : headWord[WIDTH-1:0];
    assign deq_last = !empty && headWord[WIDTH];

    assign enqFire = enq__ENA && enq__RDY;
    assign deqFire = deq__ENA && deq__RDY;
    assign enqLast = enqFire && enq_last;
    assign deqLast = deqFire && deq_last;

    assign protoHit = (enq__ENA && !enq__RDY) ||
                      (deq__ENA && !deq__RDY);

    // Storage is not reset; the head mux hides stale data when empty.
    always_ff @(posedge CLK) begin
        if (enqFire) begin
            mem[wPtr[AW-1:0]] <= {enq_last, enq_v};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wPtr <= '0;
            rPtr <= '0;
        end else begin
            if (enqFire) begin
                wPtr <= wPtr + CW'(1);
            end
            if (deqFire) begin
                rPtr <= rPtr + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            level <= '0;
        end else begin
            unique case ({enqFire, deqFire})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            msg_count <= '0;
        end else begin
            unique case ({enqLast, deqLast})
                2'b10:   msg_count <= msg_count + CW'(1);
                2'b01:   msg_count <= msg_count - CW'(1);
                default: msg_count <= msg_count;
            endcase
        end
    end

    // A full buffer with no complete message can never drain in STORE,
    // so switch to cut-through until that message's last word leaves.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cutState <= STORE;
        end else begin
            unique case (cutState)
                CUT: begin
                    if (deqLast) begin
                        cutState <= STORE;
                    end
                end
                default: begin
                    if (full && (msg_count == '0)) begin
                        cutState <= CUT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            proto_err <= 1'b0;
        end else if (protoHit) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vsim_msg_fifo.sv
// Directed testbench for vsim_msg_fifo.
// Scenario tasks run in sequence; each compares outputs inline.
module tb_vsim_msg_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic             clk;
    logic             nRst;
    logic             enqEna;
    logic [WIDTH-1:0] enqV;
    logic             enqLast;
    logic             enqRdy;
    logic             deqEna;
    logic [WIDTH-1:0] deqV;
    logic             deqLast;
    logic             deqRdy;
    logic [CW-1:0]    level;
    logic [CW-1:0]    msgCount;
    logic             protoErr;

    int tests;
    int fails;

    vsim_msg_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .CLK      (clk),
        .nRST     (nRst),
        .enq__ENA (enqEna),
        .enq_v    (enqV),
        .enq_last (enqLast),
        .enq__RDY (enqRdy),
        .deq__ENA (deqEna),
        .deq_v    (deqV),
        .deq_last (deqLast),
        .deq__RDY (deqRdy),
        .level    (level),
        .msg_count(msgCount),
        .proto_err(protoErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enqEna  = 1'b0;
        enqV    = '0;
        enqLast = 1'b0;
        deqEna  = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        nRst = 1'b0;
        tick();
        tick();
        #2 nRst = 1'b1;
        tick();
        tests++;
        if (enqRdy !== 1'b1 || deqRdy !== 1'b0) begin
            fails++;
            $display("FAIL reset_rdy enq=%b deq=%b want 1 0",
                     enqRdy, deqRdy);
        end
        tests++;
        if (deqV !== '0 || deqLast !== 1'b0) begin
            fails++;
            $display("FAIL reset_head v=%h last=%b want 0 0",
                     deqV, deqLast);
        end
        tests++;
        if (level !== '0 || msgCount !== '0 || protoErr !== 1'b0) begin
            fails++;
            $display("FAIL reset_cnt lvl=%0d msg=%0d err=%b want 0 0 0",
                     level, msgCount, protoErr);
        end
    endtask

    task automatic test_store_forward();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < 3; i++) begin
            enqEna  = 1'b1;
            enqV    = 32'hA0 + i;
            enqLast = (i == 2);
            tick();
            tests++;
            if (deqRdy !== (i == 2)) begin
                fails++;
                $display("FAIL sf_rdy%0d got %b want %b",
                         i, deqRdy, (i == 2));
            end
        end
        idle();
        tests++;
        if (level !== 5'd3 || msgCount !== 5'd1) begin
            fails++;
            $display("FAIL sf_cnt lvl=%0d msg=%0d want 3 1",
                     level, msgCount);
        end
        for (int i = 0; i < 3; i++) begin
            deqEna = 1'b1;
            w = 32'hA0 + i;
            tests++;
            if (deqV !== w || deqLast !== (i == 2) || deqRdy !== 1'b1) begin
                fails++;
                $display("FAIL sf_deq%0d got %h/%b want %h/%b",
                         i, deqV, deqLast, w, (i == 2));
            end
            tick();
        end
        idle();
        tests++;
        if (level !== '0 || msgCount !== '0 || deqRdy !== 1'b0) begin
            fails++;
            $display("FAIL sf_end lvl=%0d msg=%0d rdy=%b want 0 0 0",
                     level, msgCount, deqRdy);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp [4];
        exp[0] = 32'hB0;
        exp[1] = 32'hB1;
        exp[2] = 32'hC0;
        exp[3] = 32'hC1;
        enqEna = 1'b1; enqV = exp[0]; enqLast = 1'b0; tick();
        enqEna = 1'b1; enqV = exp[1]; enqLast = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            enqEna  = (i < 2);
            enqV    = (i < 2) ? exp[i+2] : '0;
            enqLast = (i == 1);
            deqEna  = 1'b1;
            tests++;
            if (deqRdy !== 1'b1 || deqV !== exp[i] ||
                deqLast !== (i == 1 || i == 3)) begin
                fails++;
                $display("FAIL b2b_deq%0d rdy=%b v=%h last=%b want 1 %h",
                         i, deqRdy, deqV, deqLast, exp[i]);
            end
            tick();
            if (i == 1) begin
                tests++;
                if (msgCount !== 5'd1 || level !== 5'd2) begin
                    fails++;
                    $display("FAIL b2b_msg msg=%0d lvl=%0d want 1 2",
                             msgCount, level);
                end
            end
        end
        idle();
        tests++;
        if (level !== '0 || msgCount !== '0) begin
            fails++;
            $display("FAIL b2b_end lvl=%0d msg=%0d want 0 0",
                     level, msgCount);
        end
    endtask

    task automatic test_cut_through();
        int tx;
        int rx;
        int n;
        bit badData;
        for (int i = 0; i < 16; i++) begin
            enqEna  = 1'b1;
            enqV    = 32'h300 + i;
            enqLast = 1'b0;
            tick();
        end
        idle();
        tests++;
        if (enqRdy !== 1'b0 || level !== 5'd16 || deqRdy !== 1'b0) begin
            fails++;
            $display("FAIL cut_full enqRdy=%b lvl=%0d deqRdy=%b want 0 16 0",
                     enqRdy, level, deqRdy);
        end
        tick();
        tests++;
        if (deqRdy !== 1'b1) begin
            fails++;
            $display("FAIL cut_enter deqRdy=%b want 1", deqRdy);
        end
        tx = 16;
        rx = 0;
        n  = 0;
        badData = 1'b0;
        while (rx < 20 && n < 80) begin
            enqEna  = (tx < 20) && enqRdy;
            enqV    = 32'h300 + tx;
            enqLast = (tx == 19);
            deqEna  = deqRdy;
            if (deqRdy) begin
                if (deqV !== 32'h300 + rx || deqLast !== (rx == 19)) begin
                    badData = 1'b1;
                    $display("FAIL cut_word%0d got %h/%b want %h",
                             rx, deqV, deqLast, 32'h300 + rx);
                end
                rx++;
            end
            if (enqEna) tx++;
            tick();
            n++;
        end
        idle();
        tests++;
        if (badData || rx != 20) begin
            fails++;
            $display("FAIL cut_stream rx=%0d want 20", rx);
        end
        tests++;
        if (level !== '0 || msgCount !== '0) begin
            fails++;
            $display("FAIL cut_end lvl=%0d msg=%0d want 0 0",
                     level, msgCount);
        end
        enqEna = 1'b1; enqV = 32'hD0; enqLast = 1'b0; tick();
        idle();
        tests++;
        if (deqRdy !== 1'b0) begin
            fails++;
            $display("FAIL cut_store deqRdy=%b want 0", deqRdy);
        end
        enqEna = 1'b1; enqV = 32'hD1; enqLast = 1'b1; tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            deqEna = 1'b1;
            tests++;
            if (deqRdy !== 1'b1 || deqV !== 32'hD0 + i) begin
                fails++;
                $display("FAIL cut_after%0d rdy=%b v=%h want 1 %h",
                         i, deqRdy, deqV, 32'hD0 + i);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_wrap();
        int idx;
        bit bad;
        idx = 0;
        for (int r = 0; r < 5; r++) begin
            bad = 1'b0;
            for (int k = 0; k < 16; k++) begin
                enqEna  = 1'b1;
                enqV    = 32'h100 + idx + k;
                enqLast = 1'b1;
                tick();
                if (level !== CW'(k + 1) || enqRdy !== (k < 15)) begin
                    bad = 1'b1;
                    $display("FAIL wrap_fill r%0d k%0d lvl=%0d rdy=%b",
                             r, k, level, enqRdy);
                end
            end
            idle();
            tests++;
            if (bad || level !== 5'd16 || enqRdy !== 1'b0) begin
                fails++;
                $display("FAIL wrap_full r%0d lvl=%0d rdy=%b want 16 0",
                         r, level, enqRdy);
            end
            bad = 1'b0;
            for (int k = 0; k < 16; k++) begin
                deqEna = 1'b1;
                if (deqRdy !== 1'b1 || deqV !== 32'h100 + idx + k) begin
                    bad = 1'b1;
                    $display("FAIL wrap_data r%0d k%0d got %h want %h",
                             r, k, deqV, 32'h100 + idx + k);
                end
                tick();
            end
            idle();
            tests++;
            if (bad || level !== '0 || deqRdy !== 1'b0 || enqRdy !== 1'b1) begin
                fails++;
                $display("FAIL wrap_empty r%0d lvl=%0d deqRdy=%b enqRdy=%b",
                         r, level, deqRdy, enqRdy);
            end
            idx += 16;
        end
    endtask

    task automatic test_proto_err();
        bit bad;
        tests++;
        if (protoErr !== 1'b0) begin
            fails++;
            $display("FAIL perr_clean got %b want 0", protoErr);
        end
        for (int k = 0; k < 16; k++) begin
            enqEna  = 1'b1;
            enqV    = 32'h500 + k;
            enqLast = 1'b1;
            tick();
        end
        enqEna  = 1'b1;
        enqV    = 32'hDEAD;
        enqLast = 1'b1;
        tests++;
        if (protoErr !== 1'b0) begin
            fails++;
            $display("FAIL perr_early got %b want 0", protoErr);
        end
        tick();
        idle();
        tests++;
        if (protoErr !== 1'b1 || level !== 5'd16 || msgCount !== 5'd16) begin
            fails++;
            $display("FAIL perr_enq err=%b lvl=%0d msg=%0d want 1 16 16",
                     protoErr, level, msgCount);
        end
        bad = 1'b0;
        for (int k = 0; k < 16; k++) begin
            deqEna = 1'b1;
            if (deqV !== 32'h500 + k) begin
                bad = 1'b1;
                $display("FAIL perr_data%0d got %h want %h",
                         k, deqV, 32'h500 + k);
            end
            tick();
        end
        idle();
        tests++;
        if (bad || level !== '0) begin
            fails++;
            $display("FAIL perr_drain lvl=%0d want 0", level);
        end
        deqEna = 1'b1;
        tick();
        idle();
        tests++;
        if (level !== '0 || deqRdy !== 1'b0 || protoErr !== 1'b1) begin
            fails++;
            $display("FAIL perr_deq lvl=%0d rdy=%b err=%b want 0 0 1",
                     level, deqRdy, protoErr);
        end
        tick();
        tick();
        tests++;
        if (protoErr !== 1'b1) begin
            fails++;
            $display("FAIL perr_sticky got %b want 1", protoErr);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 5; k++) begin
            enqEna  = 1'b1;
            enqV    = 32'h700 + k;
            enqLast = (k == 2);
            tick();
        end
        idle();
        tests++;
        if (level !== 5'd5 || msgCount !== 5'd1 || deqRdy !== 1'b1) begin
            fails++;
            $display("FAIL arst_pre lvl=%0d msg=%0d rdy=%b want 5 1 1",
                     level, msgCount, deqRdy);
        end
        #2 nRst = 1'b0;
        #1;
        tests++;
        if (deqRdy !== 1'b0 || level !== '0 || msgCount !== '0) begin
            fails++;
            $display("FAIL arst_now rdy=%b lvl=%0d msg=%0d want 0 0 0",
                     deqRdy, level, msgCount);
        end
        tests++;
        if (protoErr !== 1'b0 || deqV !== '0 || enqRdy !== 1'b1) begin
            fails++;
            $display("FAIL arst_out err=%b v=%h enqRdy=%b want 0 0 1",
                     protoErr, deqV, enqRdy);
        end
        tick();
        nRst = 1'b1;
        tick();
        enqEna = 1'b1; enqV = 32'h600; enqLast = 1'b0; tick();
        enqEna = 1'b1; enqV = 32'h601; enqLast = 1'b1; tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            deqEna = 1'b1;
            tests++;
            if (deqRdy !== 1'b1 || deqV !== 32'h600 + k ||
                deqLast !== (k == 1)) begin
                fails++;
                $display("FAIL arst_msg%0d rdy=%b v=%h last=%b want 1 %h",
                         k, deqRdy, deqV, deqLast, 32'h600 + k);
            end
            tick();
        end
        idle();
        tests++;
        if (level !== '0 || msgCount !== '0 || protoErr !== 1'b0) begin
            fails++;
            $display("FAIL arst_end lvl=%0d msg=%0d err=%b want 0 0 0",
                     level, msgCount, protoErr);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        nRst  = 1'b0;
        idle();
        test_reset();
        test_store_forward();
        test_back_to_back();
        test_cut_through();
        test_wrap();
        test_proto_err();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
